// File: rtl/branch_predictor.sv
// Branch predictor: a BHT of 2-bit saturating counters for conditional
// branches, a direct-mapped jalr target buffer (JTB), and two saturating
// event counters.
// Predictions are combinational reads of the pre-edge table contents.
// Updates from the resolve stage land on the next rising edge.
module branch_predictor #(
  parameter int BHT_IDX_W = 6,
  parameter int JTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_query,
  input  logic        B_type_query,
  input  logic        jalr_query,
  output logic        B_type_prediction_result,
  output logic [31:0] jalr_pc_prediciton,
  input  logic        upd_B_valid,
  input  logic [31:0] upd_B_pc,
  input  logic        upd_B_taken,
  input  logic        upd_jalr_valid,
  input  logic [31:0] upd_jalr_pc,
  input  logic [31:0] upd_jalr_target,
  input  logic        PL_flush,
  output logic [15:0] mispredict_cnt,
  output logic [15:0] resolve_cnt
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int JTB_N = 1 << JTB_IDX_W;
  localparam int TAG_W = 32 - JTB_IDX_W - 2;

  // Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CNT_RESET = 2'b01;

  // Table storage. Every BHT entry and JTB valid bit must clear
  // asynchronously, so these are flops rather than block RAM.
  logic [1:0]       bht        [BHT_N];
  logic             jtb_valid  [JTB_N];
  logic [TAG_W-1:0] jtb_tag    [JTB_N];
  logic [31:0]      jtb_target [JTB_N];

  // Index and tag extraction. Bits [1:0] are always zero for aligned code.
  logic [BHT_IDX_W-1:0] query_bht_idx;
  logic [BHT_IDX_W-1:0] upd_bht_idx;
  logic [JTB_IDX_W-1:0] query_jtb_idx;
  logic [JTB_IDX_W-1:0] upd_jtb_idx;
  logic [TAG_W-1:0]     query_tag;
  logic [TAG_W-1:0]     upd_tag;

  assign query_bht_idx = pc_query[BHT_IDX_W+1:2];
  assign upd_bht_idx   = upd_B_pc[BHT_IDX_W+1:2];
  assign query_jtb_idx = pc_query[JTB_IDX_W+1:2];
  assign upd_jtb_idx   = upd_jalr_pc[JTB_IDX_W+1:2];
  assign query_tag     = pc_query[31:JTB_IDX_W+2];
  assign upd_tag       = upd_jalr_pc[31:JTB_IDX_W+2];

  // Address bits that never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_B_pc[31:BHT_IDX_W+2], upd_B_pc[1:0],
                            upd_jalr_pc[1:0]};

  // ---------------------------------------------------------------------
  // Prediction path (zero latency, reads pre-edge contents)
  // ---------------------------------------------------------------------
  logic [1:0]  query_cnt;
  logic        jtb_hit;
  logic [31:0] pc_plus4;

  assign query_cnt = bht[query_bht_idx];
  assign pc_plus4  = pc_query + 32'd4;
  assign jtb_hit   = jalr_query && jtb_valid[query_jtb_idx] &&
                     (jtb_tag[query_jtb_idx] == query_tag);

  assign B_type_prediction_result = B_type_query && query_cnt[1];
  assign jalr_pc_prediciton       = jtb_hit ? jtb_target[query_jtb_idx]
                                            : pc_plus4;

  // ---------------------------------------------------------------------
  // BHT update: saturating increment on taken, decrement on not-taken
  // ---------------------------------------------------------------------
  logic [1:0] upd_cnt_cur;
  logic [1:0] upd_cnt_next;

  assign upd_cnt_cur = bht[upd_bht_idx];

  // Next value of the counter addressed by the resolving branch
  always_comb begin
    upd_cnt_next = upd_cnt_cur;
    if (upd_B_taken) begin
      if (upd_cnt_cur != 2'b11) upd_cnt_next = upd_cnt_cur + 2'b01;
    end else begin
      if (upd_cnt_cur != 2'b00) upd_cnt_next = upd_cnt_cur - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_N; gi++) begin : g_bht
      // One counter per entry; only the addressed entry moves
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bht[gi] <= CNT_RESET;
        end else if (upd_B_valid && (upd_bht_idx == BHT_IDX_W'(gi))) begin
          bht[gi] <= upd_cnt_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // JTB update: resolved jalr overwrites its slot unconditionally
  // ---------------------------------------------------------------------
  generate
    for (gi = 0; gi < JTB_N; gi++) begin : g_jtb
      logic sel;
      assign sel = upd_jalr_valid && (upd_jtb_idx == JTB_IDX_W'(gi));

      // Valid bit clears on reset so stale tag/target data is never used
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          jtb_valid[gi] <= 1'b0;
        end else if (sel) begin
          jtb_valid[gi] <= 1'b1;
        end
      end

      // Tag and target payload; meaningful only while the valid bit is set
      always_ff @(posedge clk) begin
        if (sel && rst_n) begin
          jtb_tag[gi]    <= upd_tag;
          jtb_target[gi] <= upd_jalr_target;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Statistics counters, both saturating at 16'hFFFF
  // ---------------------------------------------------------------------
  logic [1:0]  resolve_inc;
  logic [16:0] resolve_sum;
  logic [15:0] resolve_next;

  assign resolve_inc  = {1'b0, upd_B_valid} + {1'b0, upd_jalr_valid};
  assign resolve_sum  = {1'b0, resolve_cnt} + {15'd0, resolve_inc};
  // A carry out means the add overshot; clamp so FFFE+2 lands on FFFF
  assign resolve_next = resolve_sum[16] ? 16'hFFFF : resolve_sum[15:0];

  // Count flush cycles and resolved control-flow instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= 16'd0;
      resolve_cnt    <= 16'd0;
    end else begin
      if (PL_flush && (mispredict_cnt != 16'hFFFF)) begin
        mispredict_cnt <= mispredict_cnt + 16'd1;
      end
      resolve_cnt <= resolve_next;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_IDX_W, default 6, log2 of the branch history table (BHT) entry count.
REQ-002 SHALL have parameter JTB_IDX_W, default 4, log2 of the jalr target buffer (JTB) entry count.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_query  input  32  PC of the instruction being predicted, in the fetch/decode stage.
REQ-006 B_type_query  input  1  instruction at pc_query is a conditional branch.
REQ-007 jalr_query  input  1  instruction at pc_query is a jalr.
REQ-008 B_type_prediction_result  output  1  predicted taken (1) or not taken (0).
REQ-009 jalr_pc_prediciton  output  32  predicted jalr target.
REQ-010 upd_B_valid  input  1  a conditional branch resolved this cycle.
REQ-011 upd_B_pc  input  32  PC of the resolved branch.
REQ-012 upd_B_taken  input  1  actual branch outcome.
REQ-013 upd_jalr_valid  input  1  a jalr resolved this cycle.
REQ-014 upd_jalr_pc  input  32  PC of the resolved jalr.
REQ-015 upd_jalr_target  input  32  actual jalr target (jalr_pc_new).
REQ-016 PL_flush  input  1  pipeline flush raised by branch resolution this cycle.
REQ-017 mispredict_cnt  output  16  count of cycles with PL_flush high, saturating.
REQ-018 resolve_cnt  output  16  count of resolved B/jalr updates, saturating.

Function
REQ-019 BHT SHALL hold 2**BHT_IDX_W 2-bit saturating counters indexed by pc[BHT_IDX_W+1:2]; states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-020 B_type_prediction_result SHALL be combinational: bit[1] of the BHT entry indexed by pc_query when B_type_query=1, else 0.
REQ-021 On upd_B_valid=1, the indexed counter SHALL increment (saturate at 11) if upd_B_taken=1, else decrement (saturate at 00), at the next clk edge.
REQ-022 JTB SHALL hold 2**JTB_IDX_W entries {valid, tag=pc[31:JTB_IDX_W+2], target[31:0]} indexed by pc[JTB_IDX_W+1:2].
REQ-023 jalr_pc_prediciton SHALL be combinational: stored target on valid tag hit with jalr_query=1, else pc_query+4 (modulo 2**32).
REQ-024 On upd_jalr_valid=1, the indexed entry SHALL be written {1, tag of upd_jalr_pc, upd_jalr_target}, replacing any prior content.
REQ-025 Reads SHALL return pre-edge table contents; no write-to-read bypass in the same cycle.
REQ-026 upd_B_valid and upd_jalr_valid asserted together SHALL both take effect in the same edge.
REQ-027 Two updates to the same index on consecutive cycles SHALL apply sequentially (second sees result of first).
REQ-028 mispredict_cnt SHALL increment by 1 per clk edge with PL_flush=1, holding at 16'hFFFF.
REQ-029 resolve_cnt SHALL increment by upd_B_valid+upd_jalr_valid (0, 1 or 2) per edge, holding at 16'hFFFF; an increment of 2 from 16'hFFFE SHALL yield 16'hFFFF.
REQ-030 Predictions SHALL have zero-cycle latency; updates one-cycle latency.

Reset
REQ-031 rst_n=0 SHALL immediately set all BHT counters to 01, clear all JTB valid bits, and zero both counters, independent of clk.
REQ-032 Reset asserted mid-update SHALL discard that update; state after release is the reset state.
REQ-033 During reset, B_type_prediction_result SHALL be 0 and jalr_pc_prediciton SHALL be pc_query+4.

Verification
REQ-034 After reset, B_type_query=1, pc_query=32'h100 -> B_type_prediction_result=0; jalr_query=1 -> jalr_pc_prediciton=32'h104.
REQ-035 Two updates pc=32'h100 taken=1 -> prediction for 32'h100 becomes 1 after the first (01->10) and stays 1; three not-taken updates then -> 0 (11->10->01->00).
REQ-036 upd_jalr pc=32'h200, target=32'h4000 -> query 32'h200 returns 32'h4000; query 32'h1200 (same index, different tag) returns 32'h1204.
REQ-037 Same-cycle query and update on pc=32'h300 -> query returns old value; next cycle returns new value.
REQ-038 PL_flush held 70000 cycles -> mispredict_cnt=16'hFFFF; simultaneous B and jalr updates -> resolve_cnt +2 per edge.
REQ-039 Assert rst_n=0 between edges after training 32'h100 to 11 -> prediction 0 immediately, counters 0.
